// File: rtl/decoder3e_scan.sv
// decoder3e_scan: scan sequencer driving n/ena of a 3-to-8 enabled decoder.
// Steps n through lines 0..7, holding each for dwell+1 cycles. A scan runs
// once or repeats continuously. All outputs are registered.
// Optional macro DECODER3E_SCAN_BLANK_EN adds one ena=0 cycle between lines
// to prevent ghosting.
// Ports:
//   clk   - clock, rising edge
//   clrn  - synchronous active-low reset
//   start - begin a scan, honoured only in IDLE
//   stop  - abort a scan
//   cont  - 1 = continuous, 0 = one-shot, latched at start
//   dwell - cycles per line minus one, latched at start
//   n     - line index to the decoder
//   ena   - decoder enable
//   busy  - scan in progress
//   done  - one-cycle pulse at the end of a one-shot scan
//   wrap  - one-cycle pulse when a continuous scan wraps from line 7 to line 0
module decoder3e_scan #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic               start,
   input  logic               stop,
   input  logic               cont,
   input  logic [DWELL_W-1:0] dwell,
   output logic [2:0]         n,
   output logic               ena,
   output logic               busy,
   output logic               done,
   output logic               wrap
);
`ifdef DECODER3E_SCAN_BLANK_EN
   typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
`else
   typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif
   state_t             state, state_d;
   logic [DWELL_W-1:0] cnt, cnt_d, dwell_q, dwell_d;
   logic               cont_q, cont_d;
   logic [2:0]         n_d;
   logic               ena_d, done_d, wrap_d;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (!clrn) begin
         state   <= IDLE;
         cnt     <= '0;
         dwell_q <= '0;
         cont_q  <= 1'b0;
         n       <= 3'd0;
         ena     <= 1'b0;
         done    <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         dwell_q <= dwell_d;
         cont_q  <= cont_d;
         n       <= n_d;
         ena     <= ena_d;
         done    <= done_d;
         wrap    <= wrap_d;
      end
   end
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      dwell_d = dwell_q;
      cont_d  = cont_q;
      n_d     = n;
      ena_d   = ena;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      case (state)
         IDLE: begin
            n_d   = 3'd0;
            ena_d = 1'b0;
            cnt_d = '0;
            if (start && !stop) begin
               dwell_d = dwell;
               cont_d  = cont;
               ena_d   = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (stop) begin
               state_d = IDLE;
               n_d     = 3'd0;
               ena_d   = 1'b0;
               cnt_d   = '0;
            end else if (cnt != dwell_q) begin
               cnt_d = cnt + DWELL_W'(1);
            end else begin
               cnt_d = '0;
               if (n == 3'd7 && !cont_q) begin
                  state_d = IDLE;
                  n_d     = 3'd0;
                  ena_d   = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  // n is 3 bits, so line 7 + 1 rolls over to line 0
                  wrap_d = n == 3'd7;
`ifdef DECODER3E_SCAN_BLANK_EN
                  state_d = BLANK;
                  ena_d   = 1'b0;
`else
                  n_d = n + 3'd1;
`endif
               end
            end
         end
`ifdef DECODER3E_SCAN_BLANK_EN
         BLANK: begin
            if (stop) begin
               state_d = IDLE;
               n_d     = 3'd0;
               ena_d   = 1'b0;
            end else begin
               state_d = SCAN;
               n_d     = n + 3'd1;
               ena_d   = 1'b1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            n_d     = 3'd0;
            ena_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_decoder3e_scan.sv
// tb_decoder3e_scan: directed self-checking bench for decoder3e_scan.
// Observed outputs are packed as {n, ena, busy, done, wrap}.
// Expectations follow DECODER3E_SCAN_BLANK_EN when it is defined.
module tb_decoder3e_scan;
`ifdef DECODER3E_SCAN_BLANK_EN
   localparam bit BLK = 1'b1;
`else
   localparam bit BLK = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       clrn = 1'b0, start = 1'b0, stop = 1'b0, cont = 1'b0;
   logic [7:0] dwell = 8'd0;
   logic [2:0] n;
   logic       ena, busy, done, wrap;
   logic [6:0] obs;
   int         checks = 0, failures = 0;

   decoder3e_scan #(.DWELL_W(8)) dut (
      .clk(clk), .clrn(clrn), .start(start), .stop(stop), .cont(cont),
      .dwell(dwell), .n(n), .ena(ena), .busy(busy), .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;
   assign obs = {n, ena, busy, done, wrap};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic go(input int dw, input bit c);
      dwell = 8'(dw);
      cont  = c;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Checks every cycle of a scan begun by go(); inj pulses start and alters
   // dwell/cont at the first cycle of line 3, which must have no effect.
   task automatic run_scan(input int dw, input bit c, input int passes, input bit inj);
      for (int p = 0; p < passes; p++) begin
         for (int l = 0; l < 8; l++) begin
            for (int d = 0; d <= dw; d++) begin
               chk("scan_line", {3'(l), 1'b1, 1'b1, 1'b0, 1'(!BLK && p > 0 && l == 0 && d == 0)});
               if (inj && l == 3 && d == 0) begin
                  start = 1'b1;
                  dwell = 8'd5;
                  cont  = ~c;
               end
               tick();
               start = 1'b0;
            end
            if (BLK && (l < 7 || c)) begin
               chk("scan_blank", {3'(l), 1'b0, 1'b1, 1'b0, 1'(l == 7)});
               tick();
            end
         end
      end
      if (!c) begin
         chk("done_pulse", 7'b000_0_0_1_0);
         tick();
         chk("after_done", 7'b000_0_0_0_0);
      end else begin
         chk("pass3_start", {3'd0, 1'b1, 1'b1, 1'b0, 1'(!BLK)});
         stop = 1'b1;
         tick();
         stop = 1'b0;
         chk("after_stop", 7'b000_0_0_0_0);
         tick();
         chk("stop_no_done", 7'b000_0_0_0_0);
      end
   endtask

   initial begin
      tick();
      tick();
      chk("reset", 7'b000_0_0_0_0);
      clrn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle", 7'b000_0_0_0_0);
      end
      go(0, 1'b0);
      run_scan(0, 1'b0, 1, 1'b0);
      go(2, 1'b1);
      run_scan(2, 1'b1, 2, 1'b0);
      go(1, 1'b0);
      run_scan(1, 1'b0, 1, 1'b0);
      go(1, 1'b0);
      run_scan(1, 1'b0, 1, 1'b1);
      go(1, 1'b0);
      repeat (3 * (2 + int'(BLK))) tick();
      chk("mid_line3", 7'b011_1_1_0_0);
      clrn = 1'b0;
      tick();
      chk("mid_reset", 7'b000_0_0_0_0);
      clrn = 1'b1;
      tick();
      chk("mid_reset_quiet", 7'b000_0_0_0_0);
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("start_stop_idle", 7'b000_0_0_0_0);
      tick();
      chk("start_stop_hold", 7'b000_0_0_0_0);
      go(255, 1'b0);
      run_scan(255, 1'b0, 1, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
